// File: rtl/cordic_nco_pipe_if.sv
// Control/sample bus between the frequency-control bank (master) and the NCO core (slave).
interface cordic_nco_pipe_if #(
  parameter int ACC_W = 36,
  parameter int OUT_W = 16
);
  logic                    en;
  logic [ACC_W-1:0]        fcw;
  logic [ACC_W-1:0]        phase_off;
  logic                    fcw_load;
  logic                    sync_clr;
  logic signed [OUT_W-1:0] sin;
  logic signed [OUT_W-1:0] cos;
  logic                    out_valid;

  modport master (output en, fcw, phase_off, fcw_load, sync_clr,
                  input  sin, cos, out_valid);
  modport slave  (input  en, fcw, phase_off, fcw_load, sync_clr,
                  output sin, cos, out_valid);
endinterface

// File: rtl/cordic_nco_pipe.sv
// Pipelined CORDIC NCO: phase accumulator, quadrant fold, unrolled rotation CORDIC, round/saturate.
// Define CORDIC_NCO_DITHER_EN to add LFSR phase dither ahead of phase truncation.
module cordic_nco_pipe #(
  parameter int ACC_W  = 36,
  parameter int PH_W   = 20,
  parameter int OUT_W  = 16,
  parameter int STAGES = 16,
  parameter int GUARD  = 3
) (
  input logic             clk,
  input logic             rst,
  cordic_nco_pipe_if.slave bus
);
  localparam int IW = OUT_W + GUARD + 1;
  localparam int ZW = PH_W + 1;
  localparam int OW = OUT_W + 2;

  // atan(2^-i) by power series; keeps the table free of real-math system calls
  function automatic real atan_r(input int i);
    real t, s, p;
    t = 1.0;
    for (int n = 0; n < i; n++) t = t / 2.0;
    if (i == 0) return 0.7853981633974483;
    s = 0.0;
    p = t;
    for (int n = 0; n < 60; n++) begin
      s = (n % 2 == 1) ? s - p / real'(2 * n + 1) : s + p / real'(2 * n + 1);
      p = p * t * t;
    end
    return s;
  endfunction

  function automatic logic signed [ZW-1:0] atan_c(input int i);
    real sc;
    sc = 1.0;
    for (int n = 0; n < PH_W; n++) sc = sc * 2.0;
    return ZW'($rtoi(atan_r(i) / 6.283185307179586 * sc + 0.5));
  endfunction

  localparam logic signed [IW-1:0] X0 =
    IW'($rtoi(real'((1 << (OUT_W - 1)) - 1) * 0.607252935 * real'(1 << GUARD) + 0.5));
  localparam logic signed [IW-1:0] RND  = IW'(1 << (GUARD - 1));
  localparam logic signed [OW-1:0] SMAX = OW'((1 << (OUT_W - 1)) - 1);

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [OW-1:0] v);
    if (v > SMAX)  return SMAX[OUT_W-1:0];
    if (v < -SMAX) return -SMAX[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  logic [ACC_W-1:0]        acc, fcw_reg, off_reg, dither;
  logic [STAGES+2:0]       vld_pipe;
  logic [PH_W-1:0]         ph;
  logic signed [IW-1:0]    x_p [0:STAGES];
  logic signed [IW-1:0]    y_p [0:STAGES];
  logic signed [ZW-1:0]    z_p [0:STAGES-1];
  logic [1:0]              q_p [0:STAGES];
  logic signed [OUT_W:0]   xs, ys;
  logic [1:0]              qs;
  logic signed [OW-1:0]    xe, ye, c_m, s_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      fcw_reg  <= '0;
      off_reg  <= '0;
      vld_pipe <= '0;
    end else begin
      if (bus.sync_clr)  acc <= '0;
      else if (bus.en)   acc <= acc + fcw_reg;
      if (bus.fcw_load) begin
        fcw_reg <= bus.fcw;
        off_reg <= bus.phase_off;
      end
      vld_pipe <= {vld_pipe[STAGES+1:0], bus.en};
    end
  end

`ifdef CORDIC_NCO_DITHER_EN
  logic [31:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst)         lfsr <= 32'h0000_0001;
    else if (bus.en) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  end
  assign dither = ACC_W'(lfsr[ACC_W-PH_W-1:0]);
`else
  assign dither = '0;
`endif

  assign ph = PH_W'((acc + off_reg + dither) >> (ACC_W - PH_W));

  // S1: quadrant split; residual angle is a quarter-turn fraction
  always_ff @(posedge clk) begin
    x_p[0] <= X0;
    y_p[0] <= '0;
    z_p[0] <= ZW'(ph[PH_W-3:0]);
    q_p[0] <= ph[PH_W-1 -: 2];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    always_ff @(posedge clk) begin
      q_p[k+1] <= q_p[k];
      if (z_p[k][ZW-1]) begin
        x_p[k+1] <= x_p[k] + (y_p[k] >>> k);
        y_p[k+1] <= y_p[k] - (x_p[k] >>> k);
      end else begin
        x_p[k+1] <= x_p[k] - (y_p[k] >>> k);
        y_p[k+1] <= y_p[k] + (x_p[k] >>> k);
      end
    end
    // the last stage's residual angle is never consumed
    if (k < STAGES - 1) begin : g_z
      localparam logic signed [ZW-1:0] AT = atan_c(k);
      always_ff @(posedge clk)
        z_p[k+1] <= z_p[k][ZW-1] ? z_p[k] + AT : z_p[k] - AT;
    end
  end

  always_ff @(posedge clk) begin
    xs <= (OUT_W+1)'((x_p[STAGES] + RND) >>> GUARD);
    ys <= (OUT_W+1)'((y_p[STAGES] + RND) >>> GUARD);
    qs <= q_p[STAGES];
  end

  always_comb begin
    xe  = {{(OW-OUT_W-1){xs[OUT_W]}}, xs};
    ye  = {{(OW-OUT_W-1){ys[OUT_W]}}, ys};
    c_m = xe;
    s_m = ye;
    case (qs)
      2'd1:    begin c_m = -ye; s_m = xe;  end
      2'd2:    begin c_m = -xe; s_m = -ye; end
      2'd3:    begin c_m = ye;  s_m = -xe; end
      default: begin c_m = xe;  s_m = ye;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sin       <= '0;
      bus.cos       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= vld_pipe[STAGES+2];
      if (vld_pipe[STAGES+2]) begin
        bus.cos <= sat(c_m);
        bus.sin <= sat(s_m);
      end
    end
  end
endmodule

// File: tb/tb_cordic_nco_pipe.sv
// Scoreboard bench for cordic_nco_pipe: ideal-trig reference model, decoupled output monitor.
module tb_cordic_nco_pipe;
  localparam int ACC_W = 36;
  localparam int PH_W  = 20;
  localparam int OUT_W = 16;
  localparam int LAT   = 19;
  localparam int TOL   = 3;
  localparam real PI   = 3.141592653589793;
  localparam longint unsigned MASK = (64'd1 << ACC_W) - 64'd1;

  typedef struct { int due; int c; int s; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  longint unsigned m_acc = 0, m_fcw = 0, m_off = 0, pend_acc = 0;
  bit pend_v = 1'b0;
  int pend_e = 0;

  cordic_nco_pipe_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  cordic_nco_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.en = 1'b0; bus.fcw = '0; bus.phase_off = '0; bus.fcw_load = 1'b0; bus.sync_clr = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int expv, input int tol);
    total++;
    if (act > expv + tol || act < expv - tol) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Expected sample straight from the phase definition: ideal cos/sin of the truncated phase
  task automatic push_exp(input longint unsigned sum, input int due);
    longint unsigned p;
    real ang;
    exp_t t;
    p = (sum & MASK) >> (ACC_W - PH_W);
    ang = 2.0 * PI * real'(p) / real'(1 << PH_W);
    t.due = due;
    t.c = int'(32767.0 * $cos(ang));
    t.s = int'(32767.0 * $sin(ang));
    exp_q.push_back(t);
  endtask

  task automatic model_step();
    longint unsigned nacc;
    int e;
    e = cyc;
    if (rst) begin
      exp_q.delete();
      pend_v = 1'b0;
      m_acc = 0; m_fcw = 0; m_off = 0;
      return;
    end
    if (pend_v) push_exp(pend_acc + m_off, pend_e + LAT);
    nacc = m_acc;
    if (bus.sync_clr)  nacc = 0;
    else if (bus.en)   nacc = (m_acc + m_fcw) & MASK;
    if (bus.fcw_load) begin
      m_fcw = longint'(bus.fcw);
      m_off = longint'(bus.phase_off);
    end
    m_acc    = nacc;
    pend_v   = bus.en;
    pend_acc = nacc;
    pend_e   = e;
  endtask

  task automatic drive(input logic r, input logic e, input logic ld, input logic clr,
                       input logic [ACC_W-1:0] f, input logic [ACC_W-1:0] o);
    @(negedge clk);
    rst = r; bus.en = e; bus.fcw_load = ld; bus.sync_clr = clr; bus.fcw = f; bus.phase_off = o;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: independent of stimulus, compares every strobe against the scoreboard
  initial begin
    int e, last_c, last_s, vc, vs;
    bit armed;
    exp_t t;
    armed = 1'b0; last_c = 0; last_s = 0;
    forever begin
      @(posedge clk);
      #1;
      e = cyc - 1;
      if (rst) begin
        armed = 1'b1;
        chk("rst_valid", int'(bus.out_valid), 0, 0);
        chk("rst_cos", int'(bus.cos), 0, 0);
        chk("rst_sin", int'(bus.sin), 0, 0);
        last_c = 0; last_s = 0;
        continue;
      end
      if (!armed) continue;
      while (exp_q.size() > 0 && exp_q[0].due < e) begin
        t = exp_q.pop_front();
        chk("missing_strobe", 0, 1, 0);
      end
      vc = int'(bus.cos);
      vs = int'(bus.sin);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0, 0);
        else begin
          t = exp_q.pop_front();
          chk("latency", e, t.due, 0);
          chk("cos", vc, t.c, TOL);
          chk("sin", vs, t.s, TOL);
          if (vc == -32768) chk("cos_neg_full", vc, -32767, 0);
          if (vs == -32768) chk("sin_neg_full", vs, -32767, 0);
        end
        last_c = vc; last_s = vs;
      end else begin
        chk("valid_known", int'(bus.out_valid === 1'b0), 1, 0);
        chk("hold_cos", vc, last_c, 0);
        chk("hold_sin", vs, last_s, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout act=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [ACC_W-1:0] offs [3];
    logic [6:0] pat;
    offs[0] = 36'h4_0000_0000; offs[1] = 36'h8_0000_0000; offs[2] = 36'hC_0000_0000;
    pat = 7'b1011001;

    // reset with en/fcw_load asserted, then quiet window
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, ACC_W'({$urandom(), $urandom()}), ACC_W'({$urandom(), $urandom()}));
    idle(25);

    // single token at phase 0
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(24);

    // quarter-turn offsets
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, offs[i]);
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      idle(3);
    end
    idle(20);

    // 1/16-turn steps, continuous en across an accumulator wrap
    drive(1'b0, 1'b0, 1'b1, 1'b1, 36'h1_0000_0000, '0);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

    // load coinciding with en, then sync_clr with en mid-stream
    drive(1'b0, 1'b1, 1'b1, 1'b0, 36'h0_C000_0000, 36'h2_3456_789A);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(25);

    // gapped en pattern, then the same pattern killed by a mid-stream reset
    for (int i = 0; i < 7; i++) drive(1'b0, pat[i], 1'b0, 1'b0, '0, '0);
    idle(25);
    for (int i = 0; i < 7; i++) drive(1'b0, pat[i], 1'b0, 1'b0, '0, '0);
    idle(6);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(25);

    // randomized traffic
    drive(1'b0, 1'b0, 1'b1, 1'b0, ACC_W'({$urandom(), $urandom()}), ACC_W'({$urandom(), $urandom()}));
    for (int i = 0; i < 300; i++)
      drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 31) == 0),
            ACC_W'({$urandom(), $urandom()}), ACC_W'({$urandom(), $urandom()}));
    idle(30);

    chk("queue_empty", exp_q.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
